// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and other FIFO consumers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } uart_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;

  localparam int unsigned DEFAULT_FIFO_LAT = 3;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: wraps every CLKS_PER_BIT cycles and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear_i,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt_o,
  output logic                            bit_end_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end_o = !clear_i && (cnt_q == CW'(CLKS_PER_BIT - 1));
    cnt_d     = cnt_q + 1'b1;
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from an upstream sync_fifo with a single-cycle rd pulse and sends each
// as a start bit, DBITS data bits LSB-first and one stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBITS        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_LAT     = DEFAULT_FIFO_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DBITS + 1);
  localparam int unsigned LAT_W  = $clog2(FIFO_LAT + 1);

  uart_state_e       state_q;
  logic              tx_q;
  logic              fifo_rd_q;
  logic              busy_q;
  logic              frame_done_q;
  logic [DBITS-1:0]  shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [LAT_W-1:0]  wait_cnt_q;

  logic [BAUD_W-1:0] baud_cnt;
  logic              bit_end;
  logic              baud_clear;

  // Held at zero outside the serial states, so START bit 0 starts with a fresh count.
  assign baud_clear = !(state_q inside {S_START, S_DATA, S_STOP});

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (baud_clear),
    .cnt_o    (baud_cnt),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_q         <= TX_IDLE_LEVEL;
      fifo_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= TX_IDLE_LEVEL;
          if (!fifo_empty) begin
            state_q   <= S_REQ;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_REQ: begin
          fifo_rd_q  <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == LAT_W'(FIFO_LAT - 1)) begin
            shift_q <= fifo_dout;
            tx_q    <= START_LEVEL;
            state_q <= S_START;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == BIT_W'(DBITS - 1)) begin
              tx_q    <= TX_IDLE_LEVEL;
              state_q <= S_STOP;
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          // Registered pulse is set one cycle early so it lands on the last stop cycle.
          if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 2)) begin
            frame_done_q <= 1'b1;
          end
          if (bit_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd    = fifo_rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx driven by a 4-deep sync_fifo model that pops on the rd falling edge.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int unsigned DBITS = 8;
  localparam int unsigned CPB   = 4;
  localparam int unsigned LAT   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dout = '0;
  logic       fifo_rd, tx, busy, frame_done;

  always #5 clock = ~clock;

  fifo_uart_tx #(
    .DBITS       (DBITS),
    .CLKS_PER_BIT(CPB),
    .FIFO_LAT    (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sync_fifo model: commit on rd 1->0, data reaches fifo_dout two cycles after commit.
  logic [7:0]  mem [4];
  int unsigned wp = 0, rp = 0, cnt = 0;
  logic        wr = 1'b0;
  logic [7:0]  wdata = '0;
  logic        rd_prev = 1'b0;
  logic [7:0]  stage = '0;

  assign fifo_empty = (cnt == 0);

  always @(posedge clock) begin
    int unsigned c;
    c = cnt;
    rd_prev   <= fifo_rd;
    fifo_dout <= stage;
    if (rd_prev && !fifo_rd && cnt != 0) begin
      stage <= mem[rp];
      rp    <= (rp + 1) % 4;
      c     = c - 1;
    end
    if (wr && cnt < 4) begin
      mem[wp] <= wdata;
      wp      <= (wp + 1) % 4;
      c       = c + 1;
    end
    cnt <= c;
  end

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned n_rd = 0, n_fd = 0, n_busy = 0, rise_cyc = 0;
  logic        rd_s = 1'b0;
  logic        seen_rise = 1'b0;

  always @(negedge clock) begin
    if (fifo_rd) begin
      check_eq("rd_one_cycle", rd_s, 1'b0);
      if (!rd_s) begin
        if (seen_rise) check_eq("rd_spacing", (cyc - rise_cyc) >= LAT + 1, 1'b1);
        seen_rise <= 1'b1;
        rise_cyc  <= cyc;
        n_rd      <= n_rd + 1;
      end
    end
    rd_s <= fifo_rd;
    if (frame_done) n_fd <= n_fd + 1;
    if (busy) n_busy <= n_busy + 1;
    if (dut.state_q == S_IDLE) check_eq("tx_idle_high", tx, 1'b1);
  end

  task automatic push(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    @(negedge clock);
    wr    = 1'b0;
  endtask

  task automatic wait_rd(output int unsigned n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fifo_rd && n < 100);
  endtask

  // Captures 40 consecutive cycles from the tx falling edge and compares the whole frame.
  task automatic expect_frame(input logic [7:0] b);
    logic [39:0] obs_tx, exp_tx, obs_fd, exp_fd;
    logic        v;
    int unsigned n;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int k = 0; k < 4; k++) exp_tx[i*4+k] = v;
    end
    exp_fd = 40'd1 << 39;
    n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq("frame_start_seen", n < 300, 1'b1);
    check_eq("rd_to_tx_cycles", cyc - rise_cyc, 1 + LAT);
    for (int i = 0; i < 40; i++) begin
      obs_tx[i] = tx;
      obs_fd[i] = frame_done;
      if (i < 39) @(negedge clock);
    end
    check_eq("frame_tx_bits", obs_tx, exp_tx);
    check_eq("frame_done_pos", obs_fd, exp_fd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s_rd, s_fd, s_busy, n;
    logic        any_rd, any_low, any_busy;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_rd", fifo_rd, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // single word
    s_rd = n_rd; s_fd = n_fd; s_busy = n_busy;
    push(8'hA5);
    expect_frame(8'hA5);
    repeat (10) @(negedge clock);
    check_eq("s1_rd_pulses", n_rd - s_rd, 1);
    check_eq("s1_frame_done", n_fd - s_fd, 1);
    check_eq("s1_busy_cycles", n_busy - s_busy, 44);

    // three queued words, back to back
    s_rd = n_rd; s_fd = n_fd; s_busy = n_busy;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    expect_frame(8'h01);
    wait_rd(n);
    check_eq("s2_gap1", n, 2);
    expect_frame(8'h80);
    wait_rd(n);
    check_eq("s2_gap2", n, 2);
    expect_frame(8'hFF);
    repeat (10) @(negedge clock);
    check_eq("s2_fifo_empty", fifo_empty, 1'b1);
    check_eq("s2_rd_pulses", n_rd - s_rd, 3);
    check_eq("s2_frame_done", n_fd - s_fd, 3);
    check_eq("s2_busy_cycles", n_busy - s_busy, 132);

    // empty FIFO stays quiet
    any_rd = 1'b0; any_low = 1'b0; any_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      any_rd   |= fifo_rd;
      any_low  |= !tx;
      any_busy |= busy;
    end
    check_eq("s3_no_rd", any_rd, 1'b0);
    check_eq("s3_tx_high", any_low, 1'b0);
    check_eq("s3_not_busy", any_busy, 1'b0);

    // reset in the middle of DATA
    push(8'h00);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_eq("s4_start_seen", n < 100, 1'b1);
    repeat (CPB + 10) @(negedge clock);
    check_eq("s4_pre_reset_tx", tx, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("s4_async_tx", tx, 1'b1);
    check_eq("s4_async_busy", busy, 1'b0);
    check_eq("s4_async_rd", fifo_rd, 1'b0);
    check_eq("s4_async_fd", frame_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    s_rd = n_rd;
    any_low = 1'b0; any_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      any_low  |= !tx;
      any_busy |= busy;
    end
    check_eq("s4_no_rd_after", n_rd - s_rd, 0);
    check_eq("s4_tx_high_after", any_low, 1'b0);
    check_eq("s4_idle_after", any_busy, 1'b0);

    // full FIFO while sending
    reset = 1'b1;
    push(8'h3C);
    push(8'hC3);
    push(8'h5A);
    push(8'h96);
    reset = 1'b0;
    s_rd = n_rd; s_fd = n_fd;
    fork
      begin
        expect_frame(8'h3C);
        expect_frame(8'hC3);
        expect_frame(8'h5A);
        expect_frame(8'h96);
        expect_frame(8'h7E);
      end
      begin
        repeat (15) @(negedge clock);
        push(8'h7E);
      end
    join
    repeat (10) @(negedge clock);
    check_eq("s5_rd_pulses", n_rd - s_rd, 5);
    check_eq("s5_frame_done", n_fd - s_fd, 5);
    check_eq("s5_fifo_empty", fifo_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
